i2c_temp_responder: RTL

//  I2C target that emulates the on-board temperature sensor at the far end of the sensor bus.

---
 rtl/i2c_temp_responder_if.sv | 10 +
 rtl/i2c_temp_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_temp_responder_if.sv
// I2C bus pins between the thermostat master and the emulated temperature sensor.
// The target only ever pulls SDA low (open-drain), so it exposes an output-enable.
interface i2c_temp_responder_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (output scl, output sda_in, input sda_oe);
  modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_temp_responder.sv
// I2C target emulating the board temperature sensor: register-pointer writes, auto-increment
// reads of a coherent temperature snapshot, config register at 0x03 and an ID register at 0x0B.
module i2c_temp_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h4B,
  parameter logic [7:0]  ID_VALUE    = 8'hCB,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_temp_responder_if.slave   bus,
  input  logic [15:0]           temp_value,
  output logic                  busy,
  output logic [7:0]            config_reg
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_TX_ACK,
    S_IGNORE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]      shreg_q, shreg_d;
  logic [BYTE_W-1:0]      txsh_q, txsh_d;
  logic [BYTE_W-1:0]      ptr_q, ptr_d;
  logic [15:0]            shadow_q, shadow_d;
  logic [BYTE_W-1:0]      cfg_q, cfg_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   rw_q, rw_d;
  logic                   first_q, first_d;
  logic                   ack_q, ack_d;

  logic scl_s_c, sda_s_c;
  logic scl_rise_c, scl_fall_c, start_c, stop_c;

  // Synchronized levels and bus events derived from the history flop.
  assign scl_s_c    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s_c    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_c = scl_s_c & ~scl_prev_q;
  assign scl_fall_c = ~scl_s_c & scl_prev_q;
  assign start_c    = scl_s_c & scl_prev_q & sda_prev_q & ~sda_s_c;
  assign stop_c     = scl_s_c & scl_prev_q & ~sda_prev_q & sda_s_c;

  // Read-side register map.
  function automatic logic [7:0] rd_byte(input logic [7:0] ptr, input logic [15:0] shadow,
                                         input logic [7:0] cfg);
    case (ptr)
      8'h00:   rd_byte = shadow[15:8];
      8'h01:   rd_byte = shadow[7:0];
      8'h03:   rd_byte = cfg;
      8'h0B:   rd_byte = ID_VALUE;
      default: rd_byte = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      txsh_q     <= '0;
      ptr_q      <= '0;
      shadow_q   <= '0;
      cfg_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
      scl_prev_q <= scl_s_c;
      sda_prev_q <= sda_s_c;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      txsh_q     <= txsh_d;
      ptr_q      <= ptr_d;
      shadow_q   <= shadow_d;
      cfg_q      <= cfg_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    txsh_d    = txsh_q;
    ptr_d     = ptr_q;
    shadow_d  = shadow_q;
    cfg_d     = cfg_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    first_d   = first_q;
    ack_d     = ack_q;

    if (stop_c) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;

        S_ADDR: begin
          if (scl_rise_c) begin
            shreg_d   = {shreg_q[6:0], sda_s_c};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_c && bit_cnt_q == 4'd8) begin
            if (shreg_q[7:1] == DEV_ADDR) begin
              state_d  = S_ADDR_ACK;
              busy_d   = 1'b1;
              sda_oe_d = 1'b1;
              rw_d     = shreg_q[0];
            end else begin
              state_d  = S_IGNORE;
              busy_d   = 1'b0;
              sda_oe_d = 1'b0;
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall_c) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              // Snapshot once per read burst so MSB/LSB come from the same sample.
              state_d  = S_TX;
              shadow_d = temp_value;
              txsh_d   = rd_byte(ptr_q, temp_value, cfg_q);
              sda_oe_d = ~txsh_d[7];
            end else begin
              state_d  = S_RX;
              first_d  = 1'b1;
              sda_oe_d = 1'b0;
            end
          end
        end

        S_RX: begin
          if (scl_rise_c) begin
            shreg_d   = {shreg_q[6:0], sda_s_c};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_c && bit_cnt_q == 4'd8) begin
            state_d  = S_RX_ACK;
            sda_oe_d = 1'b1;
            if (first_q) begin
              ptr_d   = shreg_q;
              first_d = 1'b0;
            end else begin
              if (ptr_q == 8'h03) cfg_d = shreg_q;
              ptr_d = ptr_q + 8'd1;
            end
          end
        end

        S_RX_ACK: begin
          if (scl_fall_c) begin
            state_d   = S_RX;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end
        end

        S_TX: begin
          if (scl_rise_c) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_c) begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = S_TX_ACK;
              sda_oe_d = 1'b0;
              ack_d    = 1'b0;
            end else begin
              txsh_d   = {txsh_q[6:0], 1'b0};
              sda_oe_d = ~txsh_q[6];
            end
          end
        end

        S_TX_ACK: begin
          if (scl_rise_c) begin
            if (sda_s_c) begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end else begin
              ack_d = 1'b1;
              ptr_d = ptr_q + 8'd1;
            end
          end else if (scl_fall_c && ack_q) begin
            state_d   = S_TX;
            bit_cnt_d = '0;
            txsh_d    = rd_byte(ptr_q, shadow_q, cfg_q);
            sda_oe_d  = ~txsh_d[7];
          end
        end

        S_IGNORE: sda_oe_d = 1'b0;

        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign busy       = busy_q;
  assign config_reg = cfg_q;

endmodule
